// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Wait-state data-memory responder for a simple dmem initiator port. A request
// seen in IDLE is latched, held for WAIT_CYCLES extra cycles in BUSY, performed
// on the last BUSY edge, and acknowledged by a one-cycle o_ready pulse in DONE.
//
// Ports
//   i_clk      : single clock, rising-edge active
//   i_reset_n  : asynchronous active-low reset (aborts any pending request)
//   i_addr     : byte address; word index is i_addr[WIDTH-1:2]
//   i_wdata    : lane-aligned write data
//   i_byteen   : byte-lane write enables, bit k covers bits [8k+7:8k]
//   i_we/i_re  : write / read request (both high is treated as a write)
//   o_rdata    : read word, zero unless o_ready is high with a good read
//   o_ready    : one-cycle completion pulse
//   o_err      : out-of-range flag, only meaningful with o_ready
//   o_busy     : high from acceptance until the completion cycle ends
// -----------------------------------------------------------------------------
module dmem_responder #(
  parameter int WIDTH       = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic [WIDTH-1:0] i_addr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [3:0]       i_byteen,
  input  logic             i_we,
  input  logic             i_re,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_ready,
  output logic             o_err,
  output logic             o_busy
);

  localparam int IDX_W = WIDTH - 2;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WIDTH-1:0] DEPTH_L    = WIDTH'(DEPTH);
  localparam logic [3:0]       WAIT_CNT_L = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [3:0]         cnt_r;
  logic [3:0]         cnt_next_s;
  logic               accept_s;
  logic               access_s;

  // Latched request; only the word index of the address is kept.
  logic [IDX_W-1:0]   idx_r;
  logic [WIDTH-1:0]   wdata_r;
  logic [3:0]         byteen_r;
  logic               we_r;

  logic               in_range_s;
  logic [AW-1:0]      mem_idx_s;

  logic [WIDTH-1:0]   rdata_r;
  logic               ready_r;
  logic               err_r;
  logic               busy_r;

  logic [WIDTH-1:0]   mem_r [DEPTH];

  // Merge new data into an old word, lane by lane, under the byte enables.
  // Only the four lanes covered by i_byteen can be written.
  function automatic logic [WIDTH-1:0] merge_bytes(
    input logic [WIDTH-1:0] old_word,
    input logic [WIDTH-1:0] new_word,
    input logic [3:0]       be
  );
    logic [WIDTH-1:0] res;
    res = old_word;
    for (int k = 0; k < 4; k++) begin
      if (((8 * k) + 8 <= WIDTH) && be[k]) begin
        res[8*k +: 8] = new_word[8*k +: 8];
      end else begin
        res[8*k +: 8] = old_word[8*k +: 8];
      end
    end
    return res;
  endfunction

  // Range decode of the latched word index.
  always_comb begin
    in_range_s = ({2'b00, idx_r} < DEPTH_L);
    mem_idx_s  = idx_r[AW-1:0];
  end

  // Next-state, wait counter and access strobe.
  always_comb begin
    state_next_s = state_r;
    cnt_next_s   = cnt_r;
    accept_s     = 1'b0;
    access_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_we || i_re) begin
          accept_s     = 1'b1;
          cnt_next_s   = WAIT_CNT_L;
          state_next_s = ST_BUSY;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (cnt_r != 4'd0) begin
          cnt_next_s   = cnt_r - 4'd1;
          state_next_s = ST_BUSY;
        end else begin
          // The access happens on this edge; DONE only reports it.
          access_s     = 1'b1;
          state_next_s = ST_DONE;
        end
      end
      ST_DONE: begin
        state_next_s = ST_IDLE;
      end
      default: begin
        cnt_next_s   = 4'd0;
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Request capture; after acceptance the live inputs are ignored.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      idx_r    <= {IDX_W{1'b0}};
      wdata_r  <= {WIDTH{1'b0}};
      byteen_r <= 4'd0;
      we_r     <= 1'b0;
    end else if (accept_s) begin
      idx_r    <= i_addr[WIDTH-1:2];
      wdata_r  <= i_wdata;
      byteen_r <= i_byteen;
      we_r     <= i_we;
    end
  end

  // Registered outputs, derived from the next state so they line up with it.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rdata_r <= {WIDTH{1'b0}};
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      busy_r  <= (state_next_s != ST_IDLE);
      ready_r <= access_s;
      err_r   <= access_s && !in_range_s;
      rdata_r <= (access_s && !we_r && in_range_s) ? mem_r[mem_idx_s]
                                                   : {WIDTH{1'b0}};
    end
  end

  // Backing array: no reset, so contents survive i_reset_n. A reset before
  // the access edge forces IDLE, so an aborted write never lands.
  always_ff @(posedge i_clk) begin
    if (access_s && we_r && in_range_s) begin
      mem_r[mem_idx_s] <= merge_bytes(mem_r[mem_idx_s], wdata_r, byteen_r);
    end
  end

  assign o_rdata = rdata_r;
  assign o_ready = ready_r;
  assign o_err   = err_r;
  assign o_busy  = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Self-checking bench: a vector table of single requests on a WAIT_CYCLES=1
// instance with a scoreboard queue of expected completions, a mid-BUSY reset
// abort sequence, and streaming-read throughput checks on WAIT_CYCLES=0 / 15.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr, wdata, rdata;
  logic [3:0]  be;
  logic        we, re, ready, err, busy;

  logic        re_h;
  logic [31:0] rdata0, rdata15;
  logic        ready0, err0, busy0, ready15, err15, busy15;

  always #5 clk = ~clk;

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(1)) u_dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(addr), .i_wdata(wdata),
    .i_byteen(be), .i_we(we), .i_re(re),
    .o_rdata(rdata), .o_ready(ready), .o_err(err), .o_busy(busy));

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(0)) u_w0 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(32'h10), .i_wdata(32'h0),
    .i_byteen(4'h0), .i_we(1'b0), .i_re(re_h),
    .o_rdata(rdata0), .o_ready(ready0), .o_err(err0), .o_busy(busy0));

  dmem_responder #(.WIDTH(32), .DEPTH(1024), .WAIT_CYCLES(15)) u_w15 (
    .i_clk(clk), .i_reset_n(rst_n), .i_addr(32'h10), .i_wdata(32'h0),
    .i_byteen(4'h0), .i_we(1'b0), .i_re(re_h),
    .o_rdata(rdata15), .o_ready(ready15), .o_err(err15), .o_busy(busy15));

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[18];
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic w, input logic r, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] b,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.we = w; v.re = r; v.addr = a; v.wdata = d; v.be = b;
    v.exp_rdata = er; v.exp_err = ee;
    return v;
  endfunction

  // Drive one request (called at a negedge with the DUT idle), scramble the
  // inputs after acceptance, and check latency, result and pulse width.
  task automatic run_req(input vec_t v, input string tag);
    exp_t e;
    exp_t got;
    int   seen;
    e.rdata = v.exp_rdata;
    e.err   = v.exp_err;
    exp_q.push_back(e);
    we = v.we; re = v.re; addr = v.addr; wdata = v.wdata; be = v.be;
    seen = 0;
    for (int k = 1; k <= 40 && seen == 0; k++) begin
      @(posedge clk);
      #1;
      we = 1'b0; re = 1'b0;
      addr = $urandom; wdata = $urandom; be = 4'($urandom);
      @(negedge clk);
      if (ready === 1'b1) begin
        seen = k;
      end else if (k == 1) begin
        chk($sformatf("%s busy", tag), 32'(busy), 32'd1);
        chk($sformatf("%s rdata before ready", tag), rdata, 32'd0);
        chk($sformatf("%s err before ready", tag), 32'(err), 32'd0);
      end
    end
    chk($sformatf("%s latency", tag), 32'(seen), 32'd3);
    got = exp_q.pop_front();
    if (seen != 0) begin
      chk($sformatf("%s rdata", tag), rdata, got.rdata);
      chk($sformatf("%s err", tag), 32'(err), 32'(got.err));
      chk($sformatf("%s busy in done", tag), 32'(busy), 32'd1);
    end
    @(negedge clk);
    chk($sformatf("%s ready width", tag), 32'(ready), 32'd0);
    chk($sformatf("%s idle busy", tag), 32'(busy), 32'd0);
    chk($sformatf("%s idle rdata", tag), rdata, 32'd0);
  endtask

  int last0, last15, np0, np15;
  logic prev0, prev15;

  initial begin
    vecs[0]  = mk(1'b1, 1'b0, 32'h10,   32'hDEADBEEF, 4'hF, 32'h0,        1'b0);
    vecs[1]  = mk(1'b0, 1'b1, 32'h10,   32'h0,        4'hF, 32'hDEADBEEF, 1'b0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h10,   32'h000000AA, 4'h1, 32'h0,        1'b0);
    vecs[3]  = mk(1'b1, 1'b0, 32'h10,   32'h55000000, 4'h8, 32'h0,        1'b0);
    vecs[4]  = mk(1'b0, 1'b1, 32'h10,   32'h0,        4'h0, 32'h55ADBEAA, 1'b0);
    vecs[5]  = mk(1'b0, 1'b1, 32'h13,   32'h0,        4'h3, 32'h55ADBEAA, 1'b0);
    vecs[6]  = mk(1'b1, 1'b0, 32'h0,    32'hCAFEF00D, 4'hF, 32'h0,        1'b0);
    vecs[7]  = mk(1'b1, 1'b0, 32'h1000, 32'h11111111, 4'hF, 32'h0,        1'b1);
    vecs[8]  = mk(1'b0, 1'b1, 32'h1000, 32'h0,        4'hF, 32'h0,        1'b1);
    vecs[9]  = mk(1'b0, 1'b1, 32'h0,    32'h0,        4'hF, 32'hCAFEF00D, 1'b0);
    vecs[10] = mk(1'b1, 1'b1, 32'h20,   32'h12345678, 4'hF, 32'h0,        1'b0);
    vecs[11] = mk(1'b0, 1'b1, 32'h20,   32'h0,        4'hF, 32'h12345678, 1'b0);
    vecs[12] = mk(1'b1, 1'b0, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0);
    vecs[13] = mk(1'b0, 1'b1, 32'h20,   32'h0,        4'hF, 32'h12345678, 1'b0);
    vecs[14] = mk(1'b1, 1'b0, 32'hFFC,  32'hA5A5A5A5, 4'hF, 32'h0,        1'b0);
    vecs[15] = mk(1'b0, 1'b1, 32'hFFC,  32'h0,        4'hF, 32'hA5A5A5A5, 1'b0);
    vecs[16] = mk(1'b1, 1'b0, 32'h10,   32'h00000000, 4'hF, 32'h0,        1'b0);
    vecs[17] = mk(1'b0, 1'b1, 32'h10,   32'h0,        4'hF, 32'h0,        1'b0);

    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 32'h0; wdata = 32'h0; be = 4'h0;
    re_h = 1'b0;
    #12;
    chk("reset ready", 32'(ready), 32'd0);
    chk("reset err",   32'(err),   32'd0);
    chk("reset busy",  32'(busy),  32'd0);
    chk("reset rdata", rdata,      32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run_req(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of BUSY during a write of all-ones to 0x10.
    we = 1'b1; re = 1'b0; addr = 32'h10; wdata = 32'hFFFFFFFF; be = 4'hF;
    @(posedge clk);
    #1;
    we = 1'b0;
    @(negedge clk);
    chk("abort busy before reset", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort async busy",  32'(busy),  32'd0);
    chk("abort async ready", 32'(ready), 32'd0);
    chk("abort async err",   32'(err),   32'd0);
    chk("abort async rdata", rdata,      32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_req(mk(1'b0, 1'b1, 32'h10, 32'h0, 4'hF, 32'h0, 1'b0), "after abort");

    // Streaming reads with i_re held high on the WAIT_CYCLES=0 and 15 copies.
    // A virtual previous pulse at cycle -1 makes the first pulse land at W+2.
    last0 = -1; last15 = -1; np0 = 0; np15 = 0; prev0 = 1'b0; prev15 = 1'b0;
    re_h = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (ready0 === 1'b1) begin
        chk("w0 pulse width", 32'(prev0), 32'd0);
        chk("w0 period", 32'(c - last0), 32'd3);
        last0 = c;
        np0++;
      end
      if (ready15 === 1'b1) begin
        chk("w15 pulse width", 32'(prev15), 32'd0);
        chk("w15 period", 32'(c - last15), 32'd18);
        last15 = c;
        np15++;
      end
      prev0  = ready0;
      prev15 = ready15;
    end
    chk("w0 pulse count",  32'(np0),  32'd27);
    chk("w15 pulse count", 32'(np15), 32'd4);
    re_h = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
